issue_scheduler: RTL and testbench



---
 rtl/sched_pkg.sv | 25 ++
 rtl/issue_scheduler_if.sv | 37 +++
 rtl/prio_pick.sv | 33 +++
 rtl/issue_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_issue_scheduler.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sched_pkg.sv
// ----------------------------------------------------------------------------
// sched_pkg: shared types and constants for the issue scheduler.
//   slot_state_e : per-slot lifecycle FREE -> DEPCAP -> WAITING -> ISSUED -> FREE
//   BS_DEFAULT   : default instruction buffer slot count
//   IDXW_DEFAULT : slot index width for BS_DEFAULT
//   idx_w()      : slot index width for an arbitrary slot count
// ----------------------------------------------------------------------------
package sched_pkg;

    localparam int unsigned BS_DEFAULT = 16;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDXW_DEFAULT = idx_w(BS_DEFAULT);

    typedef enum logic [1:0] {
        StFree    = 2'd0,
        StDepcap  = 2'd1,
        StWaiting = 2'd2,
        StIssued  = 2'd3
    } slot_state_e;

endpackage

// File: rtl/issue_scheduler_if.sv
// ----------------------------------------------------------------------------
// issue_scheduler_if: decode / dependency-table / execution side signals of
// the issue scheduler.
//   alloc_valid, alloc_ready, alloc_idx : slot allocation handshake
//   dep_vec                             : dependency vector, one cycle after alloc
//   issue_valid, issue_ready, issue_idx : issue handshake towards execution
//   complete_valid, complete_idx        : completion of an issued slot
//   occupancy, empty, full              : buffer status
// Modports: slave = scheduler side, master = environment side.
// ----------------------------------------------------------------------------
interface issue_scheduler_if #(
    parameter int unsigned BS   = sched_pkg::BS_DEFAULT,
    parameter int unsigned IDXW = sched_pkg::idx_w(BS)
);
    logic            alloc_valid;
    logic            alloc_ready;
    logic [IDXW-1:0] alloc_idx;
    logic [BS-1:0]   dep_vec;
    logic            issue_valid;
    logic [IDXW-1:0] issue_idx;
    logic            issue_ready;
    logic            complete_valid;
    logic [IDXW-1:0] complete_idx;
    logic [IDXW:0]   occupancy;
    logic            empty;
    logic            full;

    modport slave (
        input  alloc_valid, dep_vec, issue_ready, complete_valid, complete_idx,
        output alloc_ready, alloc_idx, issue_valid, issue_idx, occupancy, empty, full
    );

    modport master (
        output alloc_valid, dep_vec, issue_ready, complete_valid, complete_idx,
        input  alloc_ready, alloc_idx, issue_valid, issue_idx, occupancy, empty, full
    );
endinterface

// File: rtl/prio_pick.sv
// ----------------------------------------------------------------------------
// prio_pick: picks the first set request bit scanning upwards from start_i,
// wrapping around. N must be a power of two so the index add wraps naturally.
//   req_i   : request vector
//   start_i : index scanned first
//   valid_o : any request set
//   idx_o   : picked index (0 when nothing is requested)
// ----------------------------------------------------------------------------
module prio_pick #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        logic [IW-1:0] cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = start_i + IW'(k);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// ----------------------------------------------------------------------------
// issue_scheduler: out-of-order issue scheduler for the instruction buffer.
// Allocates free slots to decoded instructions, captures each slot's
// dependency vector one cycle after allocation, offers at most one
// dependency-free instruction per cycle and frees slots on completion.
//   clk, rst_n : clock, synchronous active-low reset
//   bus_io     : issue_scheduler_if.slave (alloc / dep_vec / issue /
//                complete handshakes and occupancy status)
// Build option SCHED_AGE_ORDER_EN: when defined, issue selection picks the
// oldest ready slot via an age matrix instead of round-robin.
// ----------------------------------------------------------------------------
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned BS = BS_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    issue_scheduler_if.slave bus_io
);

    localparam int unsigned IDXW = idx_w(BS);
    localparam int unsigned OCCW = IDXW + 1;

    slot_state_e     state_q [BS];
    slot_state_e     state_d [BS];
    // dep_q[r][c] set: slot r waits for slot c to complete
    logic [BS-1:0]   dep_q   [BS];
    logic [BS-1:0]   dep_d   [BS];
    logic            cap_valid_q, cap_valid_d;
    logic [IDXW-1:0] cap_idx_q, cap_idx_d;
    // Stalled offer: keeps issue_idx fixed until accepted
    logic            hold_q, hold_d;
    logic [IDXW-1:0] hold_idx_q, hold_idx_d;
    logic [OCCW-1:0] occ_q, occ_d;

    logic [BS-1:0]   free_vec;
    logic [BS-1:0]   ready_vec;
    logic            alloc_ready;
    logic [IDXW-1:0] alloc_idx;
    logic            alloc_fire;
    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;
    logic            issue_valid;
    logic [IDXW-1:0] issue_idx;
    logic            issue_fire;
    logic            compl_ok;
    logic [BS-1:0]   compl_mask;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < BS; i++) begin
            free_vec[i]  = (state_q[i] == StFree);
            ready_vec[i] = (state_q[i] == StWaiting) && (dep_q[i] == '0);
        end
    end

    prio_pick #(
        .N  (BS),
        .IW (IDXW)
    ) u_alloc_pick (
        .req_i   (free_vec),
        .start_i ({IDXW{1'b0}}),
        .valid_o (alloc_ready),
        .idx_o   (alloc_idx)
    );

`ifdef SCHED_AGE_ORDER_EN
    // older_q[a][b] set: slot a was allocated before slot b
    logic [BS-1:0] older_q [BS];
    logic [BS-1:0] older_d [BS];

    always_comb begin
        for (int unsigned j = 0; j < BS; j++) begin
            older_d[j] = older_q[j];
        end
        if (alloc_fire) begin
            for (int unsigned j = 0; j < BS; j++) begin
                older_d[j][alloc_idx] = (IDXW'(j) != alloc_idx);
            end
            older_d[alloc_idx] = '0;
        end
    end

    // Oldest ready slot: no other ready slot is older than it
    always_comb begin
        logic [BS-1:0] col;
        pick_valid = 1'b0;
        pick_idx   = '0;
        col        = '0;
        for (int unsigned i = 0; i < BS; i++) begin
            for (int unsigned j = 0; j < BS; j++) begin
                col[j] = older_q[j][i];
            end
            if (!pick_valid && ready_vec[i] && ((col & ready_vec) == '0)) begin
                pick_valid = 1'b1;
                pick_idx   = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < BS; j++) begin
                older_q[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < BS; j++) begin
                older_q[j] <= older_d[j];
            end
        end
    end
`else
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] rr_start;

    assign rr_start = rr_ptr_q + IDXW'(1);

    prio_pick #(
        .N  (BS),
        .IW (IDXW)
    ) u_issue_pick (
        .req_i   (ready_vec),
        .start_i (rr_start),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        rr_ptr_d = issue_fire ? issue_idx : rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= IDXW'(BS - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign issue_valid = hold_q | pick_valid;
    assign issue_idx   = hold_q ? hold_idx_q : pick_idx;
    assign issue_fire  = issue_valid & bus_io.issue_ready;
    assign alloc_fire  = bus_io.alloc_valid & alloc_ready;
    // Completions to slots that are not ISSUED are dropped
    assign compl_ok    = bus_io.complete_valid && (state_q[bus_io.complete_idx] == StIssued);
    assign compl_mask  = compl_ok ? (BS'(1) << bus_io.complete_idx) : '0;

    always_comb begin
        for (int unsigned i = 0; i < BS; i++) begin
            state_d[i] = state_q[i];
            dep_d[i]   = dep_q[i] & ~compl_mask;
        end
        // Table rows for FREE slots are stale, so only live producers are kept
        if (cap_valid_q) begin
            dep_d[cap_idx_q]   = bus_io.dep_vec & ~free_vec & ~compl_mask
                               & ~(BS'(1) << cap_idx_q);
            state_d[cap_idx_q] = StWaiting;
        end
        if (issue_fire) begin
            state_d[issue_idx] = StIssued;
        end
        if (compl_ok) begin
            state_d[bus_io.complete_idx] = StFree;
        end
        if (alloc_fire) begin
            state_d[alloc_idx] = StDepcap;
        end
        cap_valid_d = alloc_fire;
        cap_idx_d   = alloc_fire ? alloc_idx : cap_idx_q;
        hold_d      = issue_valid & ~bus_io.issue_ready;
        hold_idx_d  = issue_idx;
        occ_d       = occ_q + OCCW'(alloc_fire) - OCCW'(compl_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BS; i++) begin
                state_q[i] <= StFree;
                dep_q[i]   <= '0;
            end
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            hold_q      <= 1'b0;
            hold_idx_q  <= '0;
            occ_q       <= '0;
        end else begin
            for (int unsigned i = 0; i < BS; i++) begin
                state_q[i] <= state_d[i];
                dep_q[i]   <= dep_d[i];
            end
            cap_valid_q <= cap_valid_d;
            cap_idx_q   <= cap_idx_d;
            hold_q      <= hold_d;
            hold_idx_q  <= hold_idx_d;
            occ_q       <= occ_d;
        end
    end

    assign bus_io.alloc_ready = alloc_ready;
    assign bus_io.alloc_idx   = alloc_idx;
    assign bus_io.issue_valid = issue_valid;
    assign bus_io.issue_idx   = issue_idx;
    assign bus_io.occupancy   = occ_q;
    assign bus_io.empty       = (occ_q == '0);
    assign bus_io.full        = (occ_q == OCCW'(BS));

    a_complete_issued: assert property (@(posedge clk) disable iff (!rst_n)
        bus_io.complete_valid |-> (state_q[bus_io.complete_idx] == StIssued));

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
    import sched_pkg::*;

    localparam int BS   = BS_DEFAULT;
    localparam int IDXW = idx_w(BS);

    localparam int MFree    = 0;
    localparam int MPending = 1;
    localparam int MWaiting = 2;
    localparam int MIssued  = 3;

    logic clk = 1'b0;
    logic rst_n;

    issue_scheduler_if #(.BS(BS)) bus ();

    issue_scheduler #(.BS(BS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Reference model: slot lifecycle, set of unfinished producers per slot
    int            m_st   [BS];
    bit [BS-1:0]   m_deps [BS];
    int            m_cap;
    int            m_last;
    int            m_held;
    int            m_occ;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < BS; i++) begin
            m_st[i]   = MFree;
            m_deps[i] = '0;
        end
        m_cap  = -1;
        m_last = BS - 1;
        m_held = -1;
        m_occ  = 0;
    endfunction

    function automatic int exp_alloc_idx();
        for (int i = 0; i < BS; i++) if (m_st[i] == MFree) return i;
        return -1;
    endfunction

    function automatic int exp_offer();
        int s;
        if (m_held >= 0) return m_held;
        for (int k = 1; k <= BS; k++) begin
            s = (m_last + k) % BS;
            if (m_st[s] == MWaiting && m_deps[s] == '0) return s;
        end
        return -1;
    endfunction

    function automatic int pick_issued();
        int q[$];
        for (int i = 0; i < BS; i++) if (m_st[i] == MIssued) q.push_back(i);
        if (q.size() == 0) return -1;
        return q[$urandom_range(q.size() - 1, 0)];
    endfunction

    // One clock: compare outputs against the model, drive inputs, advance both
    task automatic step(input bit a_v, input logic [BS-1:0] dv, input bit i_r,
                        input bit c_v, input int c_i);
        int          ai;
        int          off;
        bit          cfire;
        bit [BS-1:0] row;
        ai  = exp_alloc_idx();
        off = exp_offer();
        check_eq("alloc_ready", bus.alloc_ready, (ai >= 0) ? 1 : 0);
        if (ai >= 0) check_eq("alloc_idx", bus.alloc_idx, ai);
        check_eq("issue_valid", bus.issue_valid, (off >= 0) ? 1 : 0);
        if (off >= 0) check_eq("issue_idx", bus.issue_idx, off);
        check_eq("occupancy", bus.occupancy, m_occ);
        check_eq("empty", bus.empty, (m_occ == 0) ? 1 : 0);
        check_eq("full", bus.full, (m_occ == BS) ? 1 : 0);

        bus.alloc_valid    = a_v;
        bus.dep_vec        = dv;
        bus.issue_ready    = i_r;
        bus.complete_valid = c_v;
        bus.complete_idx   = IDXW'(c_i);
        @(posedge clk);
        #1;

        cfire = c_v && (m_st[c_i] == MIssued);
        if (m_cap >= 0) begin
            row = dv;
            row[m_cap] = 1'b0;
            for (int j = 0; j < BS; j++) if (m_st[j] == MFree) row[j] = 1'b0;
            if (cfire) row[c_i] = 1'b0;
            m_deps[m_cap] = row;
            m_st[m_cap]   = MWaiting;
        end
        if (cfire) begin
            for (int r = 0; r < BS; r++) m_deps[r][c_i] = 1'b0;
            m_st[c_i] = MFree;
            m_occ--;
        end
        if (off >= 0) begin
            if (i_r) begin
                m_st[off] = MIssued;
                m_last    = off;
                m_held    = -1;
            end else begin
                m_held = off;
            end
        end else begin
            m_held = -1;
        end
        if (a_v && ai >= 0) begin
            m_st[ai] = MPending;
            m_cap    = ai;
            m_occ++;
        end else begin
            m_cap = -1;
        end
        bus.complete_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.alloc_valid    = 1'b1;
        bus.dep_vec        = BS'($urandom);
        bus.issue_ready    = 1'b1;
        bus.complete_valid = 1'b0;
        bus.complete_idx   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_eq("rst_alloc_ready", bus.alloc_ready, 1);
        check_eq("rst_alloc_idx", bus.alloc_idx, 0);
        check_eq("rst_issue_valid", bus.issue_valid, 0);
        check_eq("rst_issue_idx", bus.issue_idx, 0);
        check_eq("rst_occupancy", bus.occupancy, 0);
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_full", bus.full, 0);
    endtask

    task automatic drain();
        int c;
        int guard;
        guard = 0;
        while (m_occ > 0 && guard < 200) begin
            c = pick_issued();
            step(1'b0, '0, 1'b1, c >= 0, (c >= 0) ? c : 0);
            guard++;
        end
        check_eq("drain_empty", bus.empty, 1);
    endtask

    task automatic rand_run(input int cycles);
        int          pa;
        int          pc;
        int          c;
        int          ph;
        bit          a_v;
        bit          c_v;
        logic [BS-1:0] dv;
        for (int n = 0; n < cycles; n++) begin
            ph = (n / 400) % 3;
            pa = (ph == 0) ? 85 : ((ph == 1) ? 45 : 15);
            pc = (ph == 0) ? 20 : ((ph == 1) ? 55 : 90);
            if ($urandom_range(999, 0) == 0) begin
                do_reset();
            end else begin
                a_v = ($urandom_range(99, 0) < pa);
                dv  = ($urandom_range(3, 0) == 0) ? '0 : BS'($urandom & $urandom & $urandom);
                c   = pick_issued();
                c_v = (c >= 0) && ($urandom_range(99, 0) < pc);
                step(a_v, dv, $urandom_range(99, 0) < 70, c_v, c_v ? c : 0);
            end
        end
    endtask

    initial begin
        int g;
        rst_n              = 1'b0;
        bus.alloc_valid    = 1'b0;
        bus.dep_vec        = '0;
        bus.issue_ready    = 1'b0;
        bus.complete_valid = 1'b0;
        bus.complete_idx   = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Three independent allocs, issued in order
        repeat (3) step(1'b1, '0, 1'b1, 1'b0, 0);
        check_eq("t1_occ", bus.occupancy, 3);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 0);
        drain();

        // Slot 1 depends on slot 0, released only by slot 0's completion
        step(1'b1, '0, 1'b1, 1'b0, 0);
        step(1'b1, '0, 1'b1, 1'b0, 0);
        step(1'b0, BS'(1), 1'b1, 1'b0, 0);
        repeat (4) step(1'b0, '0, 1'b1, 1'b0, 0);
        check_eq("t2_blocked_valid", bus.issue_valid, 0);
        step(1'b0, '0, 1'b0, 1'b1, 0);
        check_eq("t2_release_valid", bus.issue_valid, 1);
        check_eq("t2_release_idx", bus.issue_idx, 1);
        drain();

        // Producer completes on the same edge as the dependent's capture
        step(1'b1, '0, 1'b1, 1'b0, 0);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        step(1'b1, '0, 1'b1, 1'b0, 0);
        step(1'b0, BS'(1), 1'b0, 1'b1, 0);
        check_eq("t3_valid", bus.issue_valid, 1);
        check_eq("t3_idx", bus.issue_idx, 1);
        drain();

        // Fill all slots, then free slot 5
        repeat (BS) step(1'b1, '0, 1'b1, 1'b0, 0);
        repeat (2) step(1'b1, '0, 1'b1, 1'b0, 0);
        check_eq("t4_full", bus.full, 1);
        check_eq("t4_alloc_ready", bus.alloc_ready, 0);
        g = 0;
        while (m_st[5] != MIssued && g < 40) begin
            step(1'b0, '0, 1'b1, 1'b0, 0);
            g++;
        end
        step(1'b0, '0, 1'b1, 1'b1, 5);
        check_eq("t4_reopen_ready", bus.alloc_ready, 1);
        check_eq("t4_reopen_idx", bus.alloc_idx, 5);
        drain();

        // Stalled offer stays on slot 2 while slot 3 is also ready
        step(1'b1, '0, 1'b1, 1'b0, 0);
        step(1'b1, '0, 1'b1, 1'b0, 0);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        step(1'b1, '0, 1'b0, 1'b0, 0);
        step(1'b1, '0, 1'b0, 1'b0, 0);
        step(1'b0, '0, 1'b0, 1'b0, 0);
        repeat (4) step(1'b0, '0, 1'b0, 1'b0, 0);
        check_eq("t5_hold_idx", bus.issue_idx, 2);
        step(1'b0, '0, 1'b1, 1'b0, 0);
        check_eq("t5_next_valid", bus.issue_valid, 1);
        check_eq("t5_next_idx", bus.issue_idx, 3);
        drain();

        // Reset with 6 slots occupied and a capture pending
        repeat (6) step(1'b1, BS'($urandom), 1'b0, 1'b0, 0);
        do_reset();
        step(1'b1, '0, 1'b0, 1'b0, 0);
        check_eq("t6_occ", bus.occupancy, 1);
        drain();

        rand_run(3600);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
